// File: rtl/branch_resolver_pkg.sv
// Shared decode constants for the branch resolver: opcode values, field geometry, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Contents: opcode values OP_BEQ..OP_RET, opcode field width (opcode sits in the top
// OPC_W bits of the instruction), branch offset field geometry (sign bit and magnitude width).
package branch_resolver_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_BEQ  = 4'd1;
  localparam logic [OPC_W-1:0] OP_BNE  = 4'd2;
  localparam logic [OPC_W-1:0] OP_BLT  = 4'd3;
  localparam logic [OPC_W-1:0] OP_JMP  = 4'd4;
  localparam logic [OPC_W-1:0] OP_CALL = 4'd5;
  localparam logic [OPC_W-1:0] OP_RET  = 4'd6;

  // Branch field: [BR_SIGN_BIT] = direction (1 = backward), [BR_MAG_W-1:0] = magnitude.
  localparam int BR_SIGN_BIT = 5;
  localparam int BR_MAG_W    = 5;
  localparam int BR_FIELD_W  = BR_SIGN_BIT + 1;

  // Resolver FSM encoding.
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

endpackage

// File: rtl/branch_resolver_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Latency: push/pop take effect at the next rising edge; o_top/o_empty/o_full are registered state.
// Backpressure: none; a pop while empty is ignored, a push while full still succeeds.
//
// Ports: i_clk, i_reset (sync, active-high), i_push, i_pop, i_push_data[AW],
//        o_top[AW] (most recent entry), o_empty, o_full.
module return_address_stack #(
  parameter int AW        = 10,
  parameter int RAS_DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_push_data,
  output logic [AW-1:0] o_top,
  output logic          o_empty,
  output logic          o_full
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [AW-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0] r_ptr;   // index of the current top entry
  logic [PW:0]   r_cnt;   // live entries, saturates at RAS_DEPTH
  logic [PW-1:0] w_wr_ptr;

  // When full, the slot after the top is the oldest entry, so wrapping the
  // pointer gives the overwrite-oldest behaviour for free.
  assign w_wr_ptr = r_ptr + PW'(1);
  assign o_top    = r_mem[r_ptr];
  assign o_empty  = (r_cnt == '0);
  assign o_full   = (r_cnt == (PW+1)'(RAS_DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_push) begin
      r_ptr <= w_wr_ptr;
      if (!o_full) r_cnt <= r_cnt + (PW+1)'(1);
    end else if (i_pop && !o_empty) begin
      r_ptr <= r_ptr - PW'(1);
      r_cnt <= r_cnt - (PW+1)'(1);
    end
  end

  // Storage needs no reset: the entry count alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (!i_reset && i_push) r_mem[w_wr_ptr] <= i_push_data;
  end

endmodule

// File: rtl/branch_resolver.sv
// Decodes control-flow instructions, resolves branches/jumps/returns and squashes wrong-path fetches.
// Latency: instruction presented in a cycle -> redirect outputs registered at the following edge.
// Backpressure: none; while squashing, each valid instruction is dropped and o_squash flags it.
//
// Ports: i_clock, i_reset (sync, active-high), i_valid, i_instruction[IW], i_ip[AW],
//        i_reg_a[DW], i_reg_b[DW] (signed for BLT), o_branch_taken, o_jump_taken,
//        o_branch_address[AW], o_squash (combinational), o_ras_error.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int IW            = 16,
  parameter int AW            = 10,
  parameter int DW            = 16,
  parameter int RAS_DEPTH     = 4,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_valid,
  input  logic [IW-1:0] i_instruction,
  input  logic [AW-1:0] i_ip,
  input  logic [DW-1:0] i_reg_a,
  input  logic [DW-1:0] i_reg_b,
  output logic          o_branch_taken,
  output logic          o_jump_taken,
  output logic [AW-1:0] o_branch_address,
  output logic          o_squash,
  output logic          o_ras_error
);

  localparam int CW = $clog2(SQUASH_CYCLES + 1);

  logic [0:0]       r_state;
  logic [CW-1:0]    r_sq_cnt;
  logic             r_branch_taken;
  logic             r_jump_taken;
  logic [AW-1:0]    r_branch_address;
  logic             r_ras_error;

  logic [OPC_W-1:0] w_opcode;
  logic             w_active;
  logic             w_is_branch;
  logic             w_cond;
  logic             w_br_taken;
  logic             w_jmp_taken;
  logic             w_ras_err;
  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_target;
  logic [AW-1:0]    w_ret_addr;
  logic [AW-1:0]    w_ras_top;
  logic             w_ras_empty;
  logic             w_ras_full;
  logic             w_unused;

  assign w_opcode = i_instruction[IW-1 -: OPC_W];
  // Bits between the opcode and the jump target carry nothing for this block.
  assign w_unused = ^i_instruction[IW-OPC_W-1:AW];

  // Only instructions seen in RUN are architecturally executed.
  assign w_active = i_valid && (r_state == ST_RUN);

  assign w_is_branch = (w_opcode == OP_BEQ) || (w_opcode == OP_BNE) || (w_opcode == OP_BLT);

  always_comb begin
    w_cond = 1'b0;
    case (w_opcode)
      OP_BEQ:  w_cond = (i_reg_a == i_reg_b);
      OP_BNE:  w_cond = (i_reg_a != i_reg_b);
      OP_BLT:  w_cond = ($signed(i_reg_a) < $signed(i_reg_b));
      default: w_cond = 1'b0;
    endcase
  end

  assign w_br_taken  = w_active && w_is_branch && w_cond;
  // A RET with nothing on the stack has no target, so it does not redirect.
  assign w_jmp_taken = w_active && ((w_opcode == OP_JMP) || (w_opcode == OP_CALL) ||
                                    ((w_opcode == OP_RET) && !w_ras_empty));
  assign w_ras_err   = w_active && (((w_opcode == OP_CALL) && w_ras_full) ||
                                    ((w_opcode == OP_RET)  && w_ras_empty));
  assign w_push      = w_active && (w_opcode == OP_CALL);
  assign w_pop       = w_active && (w_opcode == OP_RET) && !w_ras_empty;
  assign w_ret_addr  = i_ip + AW'(1);

  always_comb begin
    w_target = '0;
    case (w_opcode)
      OP_JMP, OP_CALL: w_target = i_instruction[AW-1:0];
      OP_RET:          w_target = w_ras_top;
      // Branch offset leaves unchanged, zero-extended; the fetch side applies it.
      default:         w_target = {{(AW-BR_FIELD_W){1'b0}}, i_instruction[BR_FIELD_W-1:0]};
    endcase
  end

  return_address_stack #(
    .AW        (AW),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk       (i_clock),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_ret_addr),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty),
    .o_full      (w_ras_full)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= ST_RUN;
      r_sq_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      if (w_br_taken || w_jmp_taken) begin
        r_state  <= ST_SQUASH;
        r_sq_cnt <= CW'(SQUASH_CYCLES);
      end
    end else if (i_valid) begin
      // Only real (valid) fetches count toward the wrong-path window.
      r_sq_cnt <= r_sq_cnt - CW'(1);
      if (r_sq_cnt == CW'(1)) r_state <= ST_RUN;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_branch_taken   <= 1'b0;
      r_jump_taken     <= 1'b0;
      r_branch_address <= '0;
      r_ras_error      <= 1'b0;
    end else begin
      r_branch_taken <= w_br_taken;
      r_jump_taken   <= w_jmp_taken;
      r_ras_error    <= w_ras_err;
      if (w_br_taken || w_jmp_taken) r_branch_address <= w_target;
    end
  end

  assign o_branch_taken   = r_branch_taken;
  assign o_jump_taken     = r_jump_taken;
  assign o_branch_address = r_branch_address;
  assign o_ras_error      = r_ras_error;
  assign o_squash         = (r_state == ST_SQUASH) && i_valid;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] instr = '0;
  logic [9:0]  ip = '0;
  logic [15:0] reg_a = '0;
  logic [15:0] reg_b = '0;
  logic        bt, jt, sq, rerr;
  logic [9:0]  baddr;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  branch_resolver dut (
    .i_clock          (clk),
    .i_reset          (reset),
    .i_valid          (valid),
    .i_instruction    (instr),
    .i_ip             (ip),
    .i_reg_a          (reg_a),
    .i_reg_b          (reg_b),
    .o_branch_taken   (bt),
    .o_jump_taken     (jt),
    .o_branch_address (baddr),
    .o_squash         (sq),
    .o_ras_error      (rerr)
  );

  // ---------------- reference model ----------------
  logic [9:0] m_stack[$];
  int         m_sq_left = 0;
  logic       e_bt = 0, e_jt = 0, e_err = 0;
  logic [9:0] e_addr = '0;

  always @(posedge clk) begin
    logic [3:0] op;
    logic [9:0] ra;
    logic       taken;
    if (reset) begin
      m_stack.delete();
      m_sq_left = 0;
      e_bt = 0; e_jt = 0; e_err = 0; e_addr = '0;
    end else begin
      e_bt = 0; e_jt = 0; e_err = 0;
      if (valid) begin
        if (m_sq_left > 0) begin
          m_sq_left--;
        end else begin
          op = instr[15:12];
          taken = 0;
          case (op)
            4'd1: taken = (reg_a == reg_b);
            4'd2: taken = (reg_a != reg_b);
            4'd3: taken = ($signed(reg_a) < $signed(reg_b));
            default: taken = 0;
          endcase
          if (op >= 4'd1 && op <= 4'd3 && taken) begin
            e_bt = 1; e_addr = {4'b0, instr[5:0]}; m_sq_left = 2;
          end else if (op == 4'd4) begin
            e_jt = 1; e_addr = instr[9:0]; m_sq_left = 2;
          end else if (op == 4'd5) begin
            if (m_stack.size() == 4) begin
              e_err = 1;
              void'(m_stack.pop_front());
            end
            ra = ip + 10'd1;
            m_stack.push_back(ra);
            e_jt = 1; e_addr = instr[9:0]; m_sq_left = 2;
          end else if (op == 4'd6) begin
            if (m_stack.size() == 0) begin
              e_err = 1;
            end else begin
              e_addr = m_stack.pop_back();
              e_jt = 1; m_sq_left = 2;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Continuous compare against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_branch_taken", 32'(bt), 32'(e_bt));
      chk("m_jump_taken", 32'(jt), 32'(e_jt));
      chk("m_address", 32'(baddr), 32'(e_addr));
      chk("m_ras_error", 32'(rerr), 32'(e_err));
      chk("m_squash", 32'(sq), 32'((m_sq_left > 0) && valid));
      chk("m_exclusive", 32'(bt & jt), 32'(0));
    end
  end

  // Present one cycle's inputs; returns 2 units after the edge so outputs have settled.
  task automatic drive(input logic v, input logic [15:0] in, input logic [9:0] p,
                       input logic [15:0] a, input logic [15:0] b, input logic r);
    @(posedge clk);
    #1;
    valid = v; instr = in; ip = p; reg_a = a; reg_b = b; reset = r;
    #1;
  endtask

  task automatic nop(input logic v);
    drive(v, 16'h0000, 10'h000, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    logic [15:0] vals[5];
    vals[0] = 16'h0000; vals[1] = 16'h0001; vals[2] = 16'hFFFF;
    vals[3] = 16'h8000; vals[4] = 16'h7FFF;

    // Reset state
    drive(1'b0, 16'h0, 10'h0, 16'h0, 16'h0, 1'b1);
    drive(1'b0, 16'h0, 10'h0, 16'h0, 16'h0, 1'b1);
    nop(1'b0);
    chk("rst_bt", 32'(bt), 0);
    chk("rst_jt", 32'(jt), 0);
    chk("rst_addr", 32'(baddr), 0);
    chk("rst_err", 32'(rerr), 0);
    chk("rst_sq", 32'(sq), 0);
    check_en = 1'b1;

    // 1: BEQ taken, field 6'b100011
    drive(1'b1, 16'h1023, 10'h010, 16'h0005, 16'h0005, 1'b0);
    nop(1'b1);
    chk("t1_bt", 32'(bt), 1);
    chk("t1_addr", 32'(baddr), 32'h023);
    chk("t1_sq1", 32'(sq), 1);
    nop(1'b1);
    chk("t1_bt_pulse", 32'(bt), 0);
    chk("t1_sq2", 32'(sq), 1);
    chk("t1_addr_hold", 32'(baddr), 32'h023);
    nop(1'b1);
    chk("t1_sq_end", 32'(sq), 0);

    // 2: BLT signed
    drive(1'b1, 16'h3005, 10'h020, 16'hFFFF, 16'h0001, 1'b0);
    nop(1'b1);
    chk("t2_blt_taken", 32'(bt), 1);
    nop(1'b1);
    drive(1'b1, 16'h3007, 10'h030, 16'h0001, 16'hFFFF, 1'b0);
    chk("t2_sq_before", 32'(sq), 0);
    nop(1'b1);
    chk("t2_blt_not", 32'(bt), 0);
    chk("t2_sq_after", 32'(sq), 0);

    // 3: CALL at 3FF wraps return address to 000
    drive(1'b1, 16'h5080, 10'h3FF, 16'h0, 16'h0, 1'b0);
    nop(1'b1);
    chk("t3_call_jt", 32'(jt), 1);
    chk("t3_call_addr", 32'(baddr), 32'h080);
    nop(1'b1);
    drive(1'b1, 16'h6000, 10'h081, 16'h0, 16'h0, 1'b0);
    nop(1'b1);
    chk("t3_ret_jt", 32'(jt), 1);
    chk("t3_ret_addr", 32'(baddr), 32'h000);
    nop(1'b1);
    nop(1'b0);

    // 4: overflow on 5th CALL, underflow on 5th RET
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h5100 | 16'(i), 10'(16 + i), 16'h0, 16'h0, 1'b0);
      nop(1'b1);
      chk("t4_call_err", 32'(rerr), (i == 4) ? 1 : 0);
      chk("t4_call_jt", 32'(jt), 1);
      nop(1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'h6000, 10'h200, 16'h0, 16'h0, 1'b0);
      nop(1'b1);
      if (i < 4) begin
        chk("t4_ret_jt", 32'(jt), 1);
        chk("t4_ret_addr", 32'(baddr), 32'(21 - i));
        nop(1'b1);
      end else begin
        chk("t4_ret_err", 32'(rerr), 1);
        chk("t4_ret_nojump", 32'(jt), 0);
        chk("t4_ret_nosq", 32'(sq), 0);
      end
    end

    // 5: reset during SQUASH
    drive(1'b1, 16'h4155, 10'h040, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 16'h0000, 10'h041, 16'h0, 16'h0, 1'b1);
    chk("t5_jmp_addr", 32'(baddr), 32'h155);
    nop(1'b0);
    chk("t5_rst_jt", 32'(jt), 0);
    chk("t5_rst_addr", 32'(baddr), 0);
    drive(1'b1, 16'h1005, 10'h050, 16'h0007, 16'h0007, 1'b0);
    chk("t5_beq_nosq", 32'(sq), 0);
    nop(1'b1);
    chk("t5_beq_bt", 32'(bt), 1);
    chk("t5_beq_addr", 32'(baddr), 32'h005);
    nop(1'b1);
    nop(1'b0);

    // 6: valid gaps inside SQUASH
    drive(1'b1, 16'h4222, 10'h060, 16'h0, 16'h0, 1'b0);
    nop(1'b0);
    chk("t6_gap0", 32'(sq), 0);
    nop(1'b1);
    chk("t6_drop1", 32'(sq), 1);
    nop(1'b0);
    nop(1'b0);
    nop(1'b1);
    chk("t6_drop2", 32'(sq), 1);
    nop(1'b1);
    chk("t6_run", 32'(sq), 0);

    // Randomized traffic, checked by the compare process each cycle
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] rin;
      rin = {4'($urandom_range(0, 7)), 12'($urandom)};
      drive(($urandom_range(0, 9) < 7), rin, 10'($urandom),
            vals[$urandom_range(0, 4)], vals[$urandom_range(0, 4)],
            ($urandom_range(0, 99) == 0));
    end
    nop(1'b0);
    nop(1'b0);

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
